// File: rtl/mix_columns_engine_if.sv
// Handshake bundle for mix_columns_engine: input state channel, result channel and status.
// The engine side uses the slave modport; the producer/consumer side uses master.
interface mix_columns_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic         inv;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    modport master (
        output in_valid, inv, state_in, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

    modport slave (
        input  in_valid, inv, state_in, out_ready,
        output in_ready, out_valid, state_out, busy
    );
endinterface

// File: rtl/mix_columns_engine.sv
// Column-serial AES MixColumns / InvMixColumns engine working in place on a 128-bit state,
// transforming COLS_PER_CYCLE columns per clock between two valid/ready handshakes.
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input logic            clk,
    input logic            rst,
    mix_columns_engine_if.slave bus
);

    localparam int NCOL_STEPS = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] STEP_LAST = 2'(NCOL_STEPS - 1);
    localparam logic [1:0] CPC_W = 2'(COLS_PER_CYCLE);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
            $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0][31:0]   work_q, work_d;
    logic [1:0]         step_q, step_d;
    logic               inv_q, inv_d;
    logic               load;
    logic [1:0]         col_sel;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // p0..p3 are the row-0 multiples (2,3,1,1 or e,b,d,9); other rows use them rotated.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv_mode);
        logic [3:0][7:0] a, x2, x4, x8, p0, p1, p2, p3, o;
        a = col;
        for (int r = 0; r < 4; r++) begin
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            if (inv_mode) begin
                p0[r] = x8[r] ^ x4[r] ^ x2[r];
                p1[r] = x8[r] ^ x2[r] ^ a[r];
                p2[r] = x8[r] ^ x4[r] ^ a[r];
                p3[r] = x8[r] ^ a[r];
            end else begin
                p0[r] = x2[r];
                p1[r] = x2[r] ^ a[r];
                p2[r] = a[r];
                p3[r] = a[r];
            end
        end
        o[0] = p0[0] ^ p1[1] ^ p2[2] ^ p3[3];
        o[1] = p3[0] ^ p0[1] ^ p1[2] ^ p2[3];
        o[2] = p2[0] ^ p3[1] ^ p0[2] ^ p1[3];
        o[3] = p1[0] ^ p2[1] ^ p3[2] ^ p0[3];
        return o;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            step_q  <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            step_q  <= step_d;
            inv_q   <= inv_d;
        end
    end

    // A load from DONE overrides the return to IDLE, giving back-to-back transactions.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        step_d  = step_q;
        inv_d   = inv_q;
        load    = 1'b0;
        col_sel = '0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) load = 1'b1;
            end
            RUN: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    col_sel = step_q * CPC_W + 2'(k);
                    work_d[col_sel] = mix_col(work_q[col_sel], inv_q);
                end
                if (step_q == STEP_LAST) state_d = DONE;
                else                     step_d  = step_q + 2'd1;
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) load = 1'b1;
                    else              state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            work_d  = bus.state_in;
            inv_d   = bus.inv;
            step_d  = '0;
            state_d = RUN;
        end
    end

    assign bus.in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.state_out = work_q;

endmodule
